// File: rtl/serial_alu_ctrl_pkg.sv
// Shared encodings for the bit-serial ALU: op codes and controller states.
// Pure definitions, no latency or backpressure of its own.
package alu_pkg;

   typedef logic [1:0] op_t;

   localparam op_t OP_ADD = 2'b00;
   localparam op_t OP_SUB = 2'b01;
   localparam op_t OP_AND = 2'b10;
   localparam op_t OP_OR  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic logic is_arith(input op_t op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

endpackage

// File: rtl/serial_alu_ctrl_if.sv
// Start/done request bus between the control front-end and the serial ALU.
// Master issues start/op/operands; slave returns busy, done and held result flags.
interface serial_alu_ctrl_if #(parameter int WIDTH = 8);

   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             carry_out;
   logic             zero;

   modport master (
      output start, op, a, b,
      input  busy, done, result, carry_out, zero
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, result, carry_out, zero
   );

endinterface

// File: rtl/serial_alu_ctrl_bit_slice.sv
// One-bit ALU slice: full adder plus 4:1 result mux, purely combinational.
// Zero latency; no handshake, the controller decides when the slice output is used.
module alu_bit_slice
   import alu_pkg::*;
(
   input  logic x,
   input  logic y,
   input  logic cin,
   input  op_t  op,
   output logic res,
   output logic cout
);

   logic sum;

   assign sum  = x ^ y ^ cin;
   assign cout = (x & y) | (cin & (x ^ y));

   always_comb begin
      res = sum;
      case (op)
         OP_AND:  res = x & y;
         OP_OR:   res = x | y;
         default: res = sum;
      endcase
   end

endmodule

// File: rtl/serial_alu_ctrl.sv
// Bit-serial ALU sequencer: ADD/SUB/AND/OR over WIDTH cycles, LSB first; done WIDTH+1 cycles after accept.
// Backpressure: start is only sampled in IDLE; requests while busy are dropped, not queued.
module serial_alu_ctrl
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   serial_alu_ctrl_if.slave   bus
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] sh_a;
   logic [WIDTH-1:0] sh_b;
   logic [WIDTH-1:0] sh_r;
   op_t              op_q;
   logic             carry;
   logic [CW-1:0]    cnt;

   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] result_q;
   logic             carry_out_q;
   logic             zero_q;

   logic             slice_bit;
   logic             slice_cout;
   logic [WIDTH-1:0] next_r;

   alu_bit_slice u_slice (
      .x    (sh_a[0]),
      .y    (sh_b[0]),
      .cin  (carry),
      .op   (op_q),
      .res  (slice_bit),
      .cout (slice_cout)
   );

   // The last bit enters the result on the same edge that moves to DONE,
   // so the output registers load from the shifted value, not from sh_r.
   assign next_r = {slice_bit, sh_r[WIDTH-1:1]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         sh_a        <= '0;
         sh_b        <= '0;
         sh_r        <= '0;
         op_q        <= OP_ADD;
         carry       <= 1'b0;
         cnt         <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         result_q    <= '0;
         carry_out_q <= 1'b0;
         zero_q      <= 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  sh_a   <= bus.a;
                  sh_b   <= (bus.op == OP_SUB) ? ~bus.b : bus.b;
                  op_q   <= bus.op;
                  carry  <= (bus.op == OP_SUB);
                  cnt    <= '0;
                  busy_q <= 1'b1;
                  state  <= ST_RUN;
               end
            end
            ST_RUN: begin
               sh_a <= sh_a >> 1;
               sh_b <= sh_b >> 1;
               sh_r <= next_r;
               if (is_arith(op_q))
                  carry <= slice_cout;
               cnt <= cnt + 1'b1;
               if (cnt == LAST) begin
                  state       <= ST_DONE;
                  done_q      <= 1'b1;
                  result_q    <= next_r;
                  carry_out_q <= is_arith(op_q) ? slice_cout : 1'b0;
                  zero_q      <= (next_r == '0);
               end
            end
            ST_DONE: begin
               done_q <= 1'b0;
               busy_q <= 1'b0;
               state  <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.result    = result_q;
   assign bus.carry_out = carry_out_q;
   assign bus.zero      = zero_q;

endmodule

// File: doc/serial_alu_ctrl.md
# serial_alu_ctrl

Bit-serial ALU sequencer. It reuses a single one-bit slice (full adder plus 4:1 result mux) over `WIDTH` cycles to compute ADD, SUB, AND or OR on two `WIDTH`-bit operands, LSB first. It owns operand and result shift registers, the carry flip-flop, the bit counter and the start/done handshake. It sits between the control front-end and the register file as the area-minimal ALU option.

## Interface
- `WIDTH`, default 8: operand and result width; legal range ≥ 2.
- `clk`, input, 1: sole clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: request; sampled only in IDLE.
- `op`, input, 2: operation. 00 ADD, 01 SUB, 10 AND, 11 OR. Sampled with `start`.
- `a`, input, WIDTH: operand A, sampled with `start`.
- `b`, input, WIDTH: operand B, sampled with `start`.
- `busy`, output, 1: high in RUN and DONE.
- `done`, output, 1: one-cycle pulse; result fields are valid.
- `result`, output, WIDTH: final result; held until the next accepted `start`.
- `carry_out`, output, 1: ADD gives the carry out. SUB gives no-borrow (1 iff a ≥ b unsigned). AND/OR give 0. Held with `result`.
- `zero`, output, 1: `result == 0`. Held with `result`.

## Operation
- States: IDLE, RUN, DONE.
- IDLE with `start`=1:
  - Latch `a`, `b` and `op`. For SUB, latch ~`b`.
  - Carry flip-flop := 1 for SUB, otherwise 0.
  - Bit counter := 0. Go to RUN.
- RUN, each cycle, processes bit 0 of the A/B shift registers:
  - The slice computes sum, carry, and, or.
  - The mux selects sum (op 00/01), and (10) or or (11).
  - The selected bit shifts into the result register MSB; A and B shift right.
  - The carry flip-flop takes the slice carry, for arithmetic ops only.
  - Counter increments. When counter == WIDTH-1, go to DONE.
- DONE, single cycle:
  - `done`=1.
  - Copy the shift register to `result`. `carry_out` := carry flip-flop for arithmetic ops, else 0. `zero` is updated.
  - Go to IDLE unconditionally.
- `start` in RUN or DONE is ignored. It is not queued, and `op`/`a`/`b` changes there have no effect.
- Reset values: state IDLE, `busy`=0, `done`=0, `result`=0, `carry_out`=0, `zero`=1, counter 0, carry 0.
- `rst` mid-operation aborts immediately. All outputs take reset values on the next edge, and no `done` is produced.
- Width rules:
  - Counter width is $clog2(WIDTH).
  - Wrap-around is modulo 2^WIDTH; no overflow flag.
  - SUB result is the two's complement a − b.

## Timing
- `start` sampled at edge E0 (state IDLE). Bits are processed at edges E1..E_WIDTH.
- `done` is high in the cycle after E_WIDTH and is sampled high at edge E_(WIDTH+1).
- Latency from accept to `done` is WIDTH+1 cycles.
- `result`, `carry_out` and `zero` are valid in the same cycle as `done` and stay stable until the next accepted `start` plus WIDTH+1 cycles.
- `busy` rises the cycle after E0 and falls the cycle after `done`.
- Back-to-back operation: `start` held high re-accepts in the first IDLE cycle after DONE. Throughput is one op per WIDTH+2 cycles.
- `start` and `rst` together: `rst` wins.

## Structure
- Shared package `alu_pkg` holds:
  - op encodings OP_ADD=2'b00, OP_SUB=2'b01, OP_AND=2'b10, OP_OR=2'b11;
  - state encodings ST_IDLE, ST_RUN, ST_DONE.
- One sub-module, `alu_bit_slice`:
  - wraps the existing full adder and 4:1 mux;
  - inputs: x, y, carry-in, op; outputs: result bit, carry-out.
- The controller holds the FSM, counter, shift registers, carry flip-flop and output registers.

## Test plan
- ADD, WIDTH=8, a=8'h7F, b=8'h01: `result`=8'h80, `carry_out`=0, `zero`=0. `done` is exactly 9 cycles after the accepting edge, and `busy` is high for 9 cycles.
- ADD a=8'hFF, b=8'h01, then SUB a=8'h07, b=8'h05, then SUB a=8'h05, b=8'h07:
  - first: 8'h00, carry 1, zero 1;
  - second: 8'h02, carry 1;
  - third: 8'hFE, carry 0.
- AND and OR, a=8'hF0, b=8'h3C: AND gives 8'h30, OR gives 8'hFC. `carry_out`=0 for both, even when a prior ADD left the carry at 1.
- `start` pulsed with different operands in RUN cycle 3: ignored, and the original result is produced on schedule. With `start` held high continuously, two ops complete with `done` pulses 10 cycles apart.
- `rst` asserted in RUN cycle 4: next cycle shows `busy`=0, `result`=0, `zero`=1, and `done` never pulses. A new `start` then completes normally.
- `start` and `rst` high together in IDLE: not accepted, and `busy` stays 0.
